// File: rtl/full_add1.sv
// One-bit full adder with registered copies and a saturating carry counter.
// Define FULL_ADD1_CNT_EN to build the counter; otherwise carry_cnt is 0.
module full_add1 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             A,
   input  logic             B,
   input  logic             Ci,
   output logic             S,
   output logic             Co,
   output logic             S_q,
   output logic             Co_q,
   output logic [CNT_W-1:0] carry_cnt
);

   logic [1:0] sum;

   // an unknown on any addend turns the whole 2-bit sum unknown
   assign sum = {1'b0, A} + {1'b0, B} + {1'b0, Ci};
   assign S   = sum[0];
   assign Co  = sum[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         S_q  <= 1'b0;
         Co_q <= 1'b0;
      end else begin
         S_q  <= S;
         Co_q <= Co;
      end
   end

`ifdef FULL_ADD1_CNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (Co && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign carry_cnt = cnt_q;
`else
   assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_full_add1.sv
// Scoreboard bench for full_add1: combinational truth table,
// registered path, reset behaviour and the carry counter.
module tb_full_add1;

   localparam int CW = 2;

   logic          clk;
   logic          rst;
   logic          A;
   logic          B;
   logic          Ci;
   logic          S;
   logic          Co;
   logic          S_q;
   logic          Co_q;
   logic [CW-1:0] carry_cnt;

   full_add1 #(.CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .Ci        (Ci),
      .S         (S),
      .Co        (Co),
      .S_q       (S_q),
      .Co_q      (Co_q),
      .carry_cnt (carry_cnt)
   );

   typedef struct packed {
      logic          s;
      logic          co;
      logic [CW-1:0] cnt;
   } reg_exp_t;

   logic [1:0] comb_q[$];
   reg_exp_t   reg_q[$];

   logic          m_s;
   logic          m_co;
   logic [CW-1:0] m_cnt;

   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   // expected {Co,S} worked out as an integer sum, not gate logic
   function automatic logic [1:0] ref_add(input logic [2:0] v);
      int n;
      n = int'(v[2]) + int'(v[1]) + int'(v[0]);
      return n[1:0];
   endfunction

   task automatic drive_comb(input logic [2:0] v, input string tag);
      logic [1:0] e;
      {A, B, Ci} = v;
      comb_q.push_back(ref_add(v));
      #1;
      e = comb_q.pop_front();
      chk(tag, {30'd0, Co, S}, {30'd0, e});
   endtask

   // drive at negedge, predict the edge, check #1 after it
   task automatic step(input logic [2:0] v, input logic r, input string tag);
      logic [1:0] c;
      reg_exp_t   e;
      @(negedge clk);
      {A, B, Ci} = v;
      rst = r;
      c = ref_add(v);
      if (r) begin
         m_s = 1'b0; m_co = 1'b0; m_cnt = '0;
      end else begin
         m_s  = c[0];
         m_co = c[1];
`ifdef FULL_ADD1_CNT_EN
         if (c[1] && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
`else
         m_cnt = '0;
`endif
      end
      reg_q.push_back('{s: m_s, co: m_co, cnt: m_cnt});
      @(posedge clk);
      #1;
      e = reg_q.pop_front();
      chk({tag, ".S_q"}, {31'd0, S_q}, {31'd0, e.s});
      chk({tag, ".Co_q"}, {31'd0, Co_q}, {31'd0, e.co});
      chk({tag, ".cnt"}, 32'(carry_cnt), 32'(e.cnt));
      chk({tag, ".comb"}, {30'd0, Co, S}, {30'd0, c});
   endtask

   initial begin
      rst = 1'b0;
      {A, B, Ci} = 3'b000;
      m_s = 1'b0; m_co = 1'b0; m_cnt = '0;

      for (int i = 0; i < 8; i++) begin
         drive_comb(3'(i), $sformatf("tt%0d", i));
         #99;
      end

      step(3'b000, 1'b1, "rst0");
      step(3'b000, 1'b1, "rst1");
      step(3'b111, 1'b0, "r111");

      step(3'b110, 1'b1, "midrst");
      chk("midrst.S", {31'd0, S}, 32'd0);
      chk("midrst.Co", {31'd0, Co}, 32'd1);

      for (int i = 0; i < 5; i++)
         step(3'b110, 1'b0, $sformatf("sat%0d", i));
      for (int i = 0; i < 10; i++)
         step(3'b011, 1'b0, $sformatf("hold%0d", i));

      step(3'b101, 1'b1, "rst2");
      for (int i = 0; i < 40; i++)
         step(3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
              $sformatf("rnd%0d", i));

      chk("sb.empty", 32'(comb_q.size() + reg_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/full_add1.md
FULL_ADD1 -- requirements
Module: full_add1

Interface
REQ-001 Parameter CNT_W, default 8: width of the carry-event counter; legal range 2..32.
REQ-002 clk  input  1  single clock; all registers update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 A  input  1  addend bit.
REQ-005 B  input  1  addend bit.
REQ-006 Ci  input  1  carry-in bit.
REQ-007 S  output  1  combinational sum bit.
REQ-008 Co  output  1  combinational carry-out bit.
REQ-009 S_q  output  1  registered copy of S.
REQ-010 Co_q  output  1  registered copy of Co.
REQ-011 carry_cnt  output  CNT_W  count of clock edges with Co=1; present in both builds.

Function
REQ-012 S SHALL equal A XOR B XOR Ci, with zero clock latency and no dependence on clk or rst.
REQ-013 Co SHALL equal (A AND B) OR (A AND Ci) OR (B AND Ci), with zero clock latency and no dependence on clk or rst.
REQ-014 The outputs SHALL satisfy {Co,S} = A + B + Ci (2-bit unsigned result) for all 8 input combinations.
REQ-015 S and Co SHALL settle within the same delta cycle after any input change; the design contains no combinational loop.
REQ-016 S_q and Co_q SHALL take the values of S and Co sampled at each rising clk edge when rst=0; latency is 1 cycle.
REQ-017 When FULL_ADD1_CNT_EN is defined, carry_cnt SHALL increment by 1 at each rising edge where rst=0 and Co=1.
REQ-018 carry_cnt SHALL saturate at 2^CNT_W-1 and hold that value; it does not wrap.
REQ-019 X or Z on any input SHALL propagate as X on S and Co; registered outputs capture that value unchanged.

Reset
REQ-020 At a rising edge with rst=1: S_q=0, Co_q=0, carry_cnt=0, regardless of A, B and Ci.
REQ-021 rst SHALL NOT affect S or Co.
REQ-022 rst asserted mid-operation SHALL take effect at the next rising edge; the counter does not increment on that edge even if Co=1.
REQ-023 Registered outputs are undefined before the first reset edge; the bench SHALL apply reset for at least one cycle before checking them.

Configuration
REQ-024 Macro FULL_ADD1_CNT_EN defined: the carry-event counter is compiled in and behaves per REQ-017/REQ-018.
REQ-025 Macro FULL_ADD1_CNT_EN undefined: no counter logic is built and carry_cnt SHALL be tied to constant 0; all other behaviour is unchanged.

Verification
REQ-026 Exhaustive truth table: apply {A,B,Ci} = 000, 001, 010, 011, 100, 101, 110, 111, holding each for 100 ns. Required {Co,S} = 00, 01, 01, 10, 01, 10, 10, 11 in the same order, with no clock required.
REQ-027 Registered path: rst=1 for 2 cycles, then drive {A,B,Ci}=111. At that edge S_q=1 and Co_q=1; before it, S_q=0 and Co_q=0.
REQ-028 Reset mid-run: while {A,B,Ci}=110, assert rst for 1 cycle. At that edge S_q=0, Co_q=0 and carry_cnt=0; S=0 and Co=1 stay unaffected.
REQ-029 Counter (macro defined, CNT_W=2): hold Co=1 for 5 edges. carry_cnt reads 1, 2, 3, 3, 3.
REQ-030 Counter disabled (macro undefined): hold Co=1 for 10 edges. carry_cnt stays 0.
REQ-031 Run the simulation for 1000 ns with a VCD dump enabled; S and Co match REQ-014 at every input change.
